// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code width, checker state enum and Gray/binary conversion helpers
package gray_pkg;
  localparam int GRAY_W = 4;
  typedef enum logic {UNLOCKED, LOCKED} state_e;
  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
    logic [GRAY_W-1:0] b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/gray_seq_checker_if.sv
// gray_seq_checker_if: sample bus (gray_in, valid_in, clr_err) in, status (bin_out, bin_valid, locked, wrap_pulse, err_pulse, err_sticky, err_count) out
interface gray_seq_checker_if #(parameter int WIDTH = 4, parameter int ERR_CNT_W = 8);
  logic [WIDTH-1:0] gray_in;
  logic valid_in;
  logic clr_err;
  logic [WIDTH-1:0] bin_out;
  logic bin_valid;
  logic locked;
  logic wrap_pulse;
  logic err_pulse;
  logic err_sticky;
  logic [ERR_CNT_W-1:0] err_count;
  modport master(output gray_in, valid_in, clr_err,
                 input bin_out, bin_valid, locked, wrap_pulse, err_pulse, err_sticky, err_count);
  modport slave(input gray_in, valid_in, clr_err,
                output bin_out, bin_valid, locked, wrap_pulse, err_pulse, err_sticky, err_count);
endinterface

// File: rtl/gray_to_bin.sv
// gray_to_bin: combinational Gray-to-binary converter (g_i Gray in, b_o binary out)
module gray_to_bin #(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0] g_i,
  output logic [WIDTH-1:0] b_o
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign b_o[i] = ^g_i[WIDTH-1:i];
  end
endmodule

// File: rtl/gray_seq_checker.sv
// gray_seq_checker: checks Gray samples on bus (slave) follow +1/hold order; clk, sync active-high rst; reports lock, wrap, errors
module gray_seq_checker
  import gray_pkg::*;
#(
  parameter int WIDTH     = GRAY_W,
  parameter bit HOLD_OK   = 1'b1,
  parameter int LOCK_LEN  = 2,
  parameter int ERR_CNT_W = 8
) (
  input logic clk,
  input logic rst,
  gray_seq_checker_if.slave bus
);
  localparam logic [3:0] LOCK_N = 4'(LOCK_LEN);
  state_e state_q, state_d;
  logic [WIDTH-1:0] bin, ref_q, bin_out_q;
  logic have_ref_q, bin_valid_q, wrap_q, err_pulse_q, err_sticky_q;
  logic [3:0] good_q, good_d;
  logic [ERR_CNT_W-1:0] err_count_q;
  logic inc, hold, bad, err;
  gray_to_bin #(.WIDTH(WIDTH)) u_g2b (.g_i(bus.gray_in), .b_o(bin));
  assign inc  = have_ref_q && bin == ref_q + 1'b1;
  assign hold = have_ref_q && bin == ref_q;
  assign bad  = have_ref_q && !(inc || (hold && HOLD_OK));
  assign err  = bus.valid_in && state_q == LOCKED && bad;
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    if (bus.valid_in && have_ref_q) begin
      if (bad) begin
        state_d = UNLOCKED;
        good_d  = '0;
      end else if (inc && state_q == UNLOCKED) begin
        state_d = good_q + 4'd1 == LOCK_N ? LOCKED : UNLOCKED;
        good_d  = good_q + 4'd1 == LOCK_N ? 4'd0 : good_q + 4'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= UNLOCKED;
      good_q       <= '0;
      ref_q        <= '0;
      have_ref_q   <= 1'b0;
      bin_out_q    <= '0;
      bin_valid_q  <= 1'b0;
      wrap_q       <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      bin_valid_q  <= bus.valid_in;
      wrap_q       <= bus.valid_in && inc && &ref_q && bin == '0;
      err_pulse_q  <= err;
      err_sticky_q <= err || (err_sticky_q && !bus.clr_err);
      err_count_q  <= bus.clr_err ? ERR_CNT_W'(err) : err_count_q + ERR_CNT_W'(err && !(&err_count_q));
      if (bus.valid_in) begin
        bin_out_q  <= bin;
        ref_q      <= bin;
        have_ref_q <= 1'b1;
      end
    end
  end
  assign bus.bin_out    = bin_out_q;
  assign bus.bin_valid  = bin_valid_q;
  assign bus.locked     = state_q == LOCKED;
  assign bus.wrap_pulse = wrap_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.err_count  = err_count_q;
endmodule

// File: doc/gray_seq_checker.md
Name: gray_seq_checker

Overview:
- Downstream consumer of the 4-bit Gray counter output.
- Samples `gray_count` each valid cycle, converts it to binary, and confirms each sample is the legal Gray successor of the previous one (or a permitted hold).
- Reports lock status, wrap-around events, and sequence errors.
- Used in-system as a hardware counterpart of the bench monitor/scoreboard.

Parameters:
- WIDTH, 4, Gray/binary word width.
- HOLD_OK, 1, 1 = a repeated sample is legal (counter stalled); 0 = a repeat is an error.
- LOCK_LEN, 2, consecutive legal increments required to declare lock (range 1..15).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- gray_in  input  WIDTH  Gray code sample from the counter.
- valid_in  input  1  gray_in is meaningful this cycle.
- clr_err  input  1  clears err_count and err_sticky.
- bin_out  output  WIDTH  binary equivalent of the last valid sample.
- bin_valid  output  1  one-cycle pulse: bin_out was updated.
- locked  output  1  checker is in LOCKED state.
- wrap_pulse  output  1  one-cycle pulse: legal wrap from all-ones to zero (binary).
- err_pulse  output  1  one-cycle pulse: sequence error while LOCKED.
- err_sticky  output  1  set on any error; held until clr_err or rst.
- err_count  output  ERR_CNT_W  saturating count of errors.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- All outputs are registered. Response appears the cycle after the valid_in sample.
- Reset values:
  - bin_out=0, bin_valid=0, locked=0, wrap_pulse=0, err_pulse=0, err_sticky=0, err_count=0.
  - State=UNLOCKED, have_ref=0, good_run=0, ref=0.
- Conversion:
  - b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i].
  - Expected next = ref+1 modulo 2^WIDTH.
- Sample classification (only when have_ref=1):
  - INC: bin==ref+1.
  - HOLD: bin==ref.
  - BAD: anything else, or HOLD when HOLD_OK=0.
- valid_in=0: no state change; all pulses deassert.
- Every valid sample: bin_out<=bin, bin_valid=1, ref<=bin, have_ref<=1.
- State UNLOCKED:
  - First valid sample after reset: reference only; good_run=0; no check.
  - INC: good_run++. When good_run reaches LOCK_LEN, go to LOCKED and clear good_run.
  - HOLD (legal): good_run unchanged.
  - BAD: good_run=0, stay UNLOCKED. No err_pulse, no count.
- State LOCKED:
  - INC or legal HOLD: stay LOCKED.
  - BAD: err_pulse=1, err_sticky=1, err_count+1 (saturates at all-ones), go to UNLOCKED with good_run=0. The bad sample becomes the new reference.
- wrap_pulse: INC with ref=all-ones and bin=0, in either state.
- clr_err: clears err_count and err_sticky next cycle. If it coincides with a new error: err_count=1, err_sticky=1, err_pulse=1.
- rst mid-operation: all state returns to reset values. The next valid sample is treated as the first sample.

Decomposition:
- Shared package gray_pkg holds:
  - GRAY_W=4.
  - State enum {UNLOCKED, LOCKED}.
  - Functions gray2bin and bin2gray (the bench reuses them).
- One sub-module: gray_to_bin. Combinational and parameterised by WIDTH; the checker registers its output.

Test Plan:
- rst held 2 cycles, then 16 valid samples 0000,0001,0011,0010,0110,...,1000 -> bin_out follows 0..15. locked rises 1 cycle after the third sample (LOCK_LEN=2). err_count=0.
- Continue after 1000 with 0000 -> wrap_pulse=1 for one cycle, bin_out=0, locked stays 1.
- While locked at 0011 (bin 2), inject 0101 (bin 6) -> err_pulse=1, err_sticky=1, err_count=1, locked=0. Then 0100,1100,1101 -> locked returns to 1 after 1100.
- HOLD_OK=1: repeat 0110 three times -> no error, locked held. HOLD_OK=0: the same stimulus -> err_pulse on the first repeat.
- clr_err asserted the same cycle as an injected error with err_count=5 -> err_count=1, err_sticky=1. Force 300 errors (ERR_CNT_W=8) -> err_count saturates at 255.
- rst asserted mid-stream while locked -> next cycle all outputs are 0 and state is UNLOCKED. The first following sample (e.g. 1010) produces bin_valid=1 with bin_out=12 and no error.
